control_unit_fsm: RTL and testbench
===================================

Name: control_unit_fsm

Overview:
- Instruction-sequencing control unit for the 19-bit CPU; the initiator side of the control bus.
- Drives the memory, PC, register-file and ALU control strobes from the fetched opcode and the ALU flags, in a fetch/decode/execute sequence.
- Sits between the instruction register (IR) and the control bus. It is the only driver of RD_EN, WR_EN, INC_PC, LOAD_REG, LOAD_SELECT, MODE, MUX_SELECT_A and MUX_SELECT_B.

Parameters:
- OPCODE_SIZE, 5, opcode width; taken from the constants package.
- MEM_TIMEOUT, 16, maximum wait in cycles for mem_ready before the block flags a fault.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ENABLE  input  1  run enable; sampled only at instruction boundaries.
- OPCODE  input  OPCODE_SIZE  opcode field of the IR.
- FLAGS  input  4  ALU flags: [0]=Z, [1]=C, [2]=N, [3]=V.
- mem_ready  input  1  memory completion strobe, one cycle wide.
- RD_EN  output  1  memory read enable.
- WR_EN  output  1  memory write enable.
- INC_PC  output  1  PC increment pulse.
- LOAD_REG  output  1  register load pulse.
- LOAD_SELECT  output  3  load target: 000 PC, 001 IR, 010 RegA, 011 RegB, 100 RegC.
- MODE  output  1  ALU mode: 0 arithmetic, 1 logic.
- MUX_SELECT_A  output  1  ALU operand A mux select.
- MUX_SELECT_B  output  1  ALU operand B mux select.
- halted  output  1  sticky; set by the HALT opcode or by a timeout.
- fault  output  1  sticky; set on memory timeout.

Behaviour:
- Outputs:
  - All outputs are registered (Moore).
  - Reset value of every output is 0; LOAD_SELECT resets to 000.
  - State resets to IDLE; the timeout counter resets to 0.
- Opcode map:
  - 0x00-0x07: ALU arithmetic (MODE=0).
  - 0x08-0x0F: ALU logic (MODE=1).
  - 0x10: LD.
  - 0x11: ST.
  - 0x12: JMP.
  - 0x13: BEQ (taken when Z=1).
  - 0x14: BNE (taken when Z=0).
  - 0x1F: HALT.
  - All other codes: NOP.
- ALU operand selects: MUX_SELECT_A = OPCODE[0], MUX_SELECT_B = OPCODE[1].
- States: IDLE, FETCH, DECODE, EXEC, MEM_RD, MEM_WR, HALT.
- IDLE: all strobes 0. Moves to FETCH when ENABLE=1.
- FETCH:
  - RD_EN=1 and LOAD_SELECT=001 until mem_ready.
  - In the cycle after mem_ready: LOAD_REG=1 and INC_PC=1 for exactly one cycle, RD_EN=0, then go to DECODE.
- DECODE: one cycle; latches OPCODE and FLAGS into internal registers.
- EXEC by opcode class:
  - ALU: MODE and mux selects set, LOAD_SELECT=010, LOAD_REG=1 for one cycle.
  - JMP, and BEQ/BNE when taken: LOAD_SELECT=000, LOAD_REG=1 for one cycle.
  - Branch not taken, or NOP: no strobes.
  - LD goes to MEM_RD; ST goes to MEM_WR; HALT goes to HALT.
- MEM_RD:
  - RD_EN=1 until mem_ready.
  - Next cycle: LOAD_SELECT=010, LOAD_REG=1 for one cycle.
- MEM_WR: WR_EN=1 until mem_ready, then WR_EN=0.
- Instruction boundary (end of EXEC, MEM_RD or MEM_WR): go to FETCH if ENABLE=1, otherwise IDLE. Dropping ENABLE mid-instruction never aborts the instruction.
- Timeout:
  - The counter increments while waiting in FETCH, MEM_RD or MEM_WR, and clears on mem_ready.
  - When the counter reaches MEM_TIMEOUT: fault=1, halted=1, all strobes drop to 0, go to HALT.
- HALT: absorbing state; only rst_n leaves it. All strobes 0; halted=1.
- Strobe exclusivity: RD_EN and WR_EN are never high in the same cycle. INC_PC is asserted only in the FETCH completion cycle.
- Reset mid-operation: on rst_n falling, all outputs clear immediately (asynchronously), with no completion of the pending access.
- mem_ready outside a wait state is ignored.

Decomposition:
- Constants package: OPCODE_SIZE; opcode localparams (OP_LD, OP_ST, OP_JMP, OP_BEQ, OP_BNE, OP_HALT); LOAD_SELECT encodings; the cu_state_t enum; flag bit indices.
- Sub-module cu_decoder: purely combinational; maps the latched opcode to the class (alu/ld/st/jmp/br/halt/nop), MODE and mux selects.

Test Plan:
- Reset, then ENABLE=1, opcode 0x03, mem_ready 2 cycles after RD_EN -> RD_EN high 2 cycles, then LOAD_REG=1 with LOAD_SELECT=001 and INC_PC=1, then in EXEC MODE=0, MUX_A=1, MUX_B=1, LOAD_SELECT=010, LOAD_REG=1.
- Opcode 0x10 (LD) -> after decode RD_EN held until mem_ready, then LOAD_REG=1 with LOAD_SELECT=010; WR_EN stays 0 throughout.
- BEQ with FLAGS=0001 -> LOAD_SELECT=000 and LOAD_REG=1. BEQ with FLAGS=0000 -> no load; next FETCH begins in the following cycle.
- mem_ready withheld for 16 cycles in MEM_WR -> fault=1, halted=1, WR_EN=0. State stays in HALT until rst_n is pulsed low, after which all outputs read 0.
- ENABLE dropped during MEM_RD -> the load completes, then IDLE with RD_EN=0. Reasserting ENABLE -> FETCH on the next cycle.
- rst_n asserted mid-FETCH -> RD_EN=0 without waiting for a clock edge. Opcode 0x1F -> halted=1 and no further RD_EN.

Source files
------------

// File: rtl/control_unit_fsm_pkg.sv
// Shared constants and types for the 19-bit CPU control unit.
package control_unit_fsm_pkg;

  localparam int unsigned OPCODE_SIZE = 5;

  localparam logic [OPCODE_SIZE-1:0] OP_LD   = 5'h10;
  localparam logic [OPCODE_SIZE-1:0] OP_ST   = 5'h11;
  localparam logic [OPCODE_SIZE-1:0] OP_JMP  = 5'h12;
  localparam logic [OPCODE_SIZE-1:0] OP_BEQ  = 5'h13;
  localparam logic [OPCODE_SIZE-1:0] OP_BNE  = 5'h14;
  localparam logic [OPCODE_SIZE-1:0] OP_HALT = 5'h1F;

  typedef logic [2:0] load_sel_t;

  localparam load_sel_t LS_PC   = 3'b000;
  localparam load_sel_t LS_IR   = 3'b001;
  localparam load_sel_t LS_REGA = 3'b010;
  localparam load_sel_t LS_REGB = 3'b011;
  localparam load_sel_t LS_REGC = 3'b100;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [2:0] {
    CU_IDLE,
    CU_FETCH,
    CU_DECODE,
    CU_EXEC,
    CU_MEM_RD,
    CU_MEM_WR,
    CU_HALT
  } cu_state_t;

  typedef enum logic [2:0] {
    CL_NOP,
    CL_ALU,
    CL_LD,
    CL_ST,
    CL_JMP,
    CL_BR,
    CL_HALT
  } cu_class_t;

  typedef struct packed {
    logic      rd_en;
    logic      wr_en;
    logic      inc_pc;
    logic      load_reg;
    load_sel_t load_sel;
    logic      mode;
    logic      mux_a;
    logic      mux_b;
  } cu_ctrl_t;

endpackage

// File: rtl/control_unit_fsm_if.sv
// Control bus between the control unit (master) and the datapath/memory (slave).
interface control_unit_fsm_if;
  import control_unit_fsm_pkg::*;

  logic      RD_EN;
  logic      WR_EN;
  logic      INC_PC;
  logic      LOAD_REG;
  load_sel_t LOAD_SELECT;
  logic      MODE;
  logic      MUX_SELECT_A;
  logic      MUX_SELECT_B;
  logic      mem_ready;

  modport master (
    output RD_EN, WR_EN, INC_PC, LOAD_REG, LOAD_SELECT,
    output MODE, MUX_SELECT_A, MUX_SELECT_B,
    input  mem_ready
  );

  modport slave (
    input  RD_EN, WR_EN, INC_PC, LOAD_REG, LOAD_SELECT,
    input  MODE, MUX_SELECT_A, MUX_SELECT_B,
    output mem_ready
  );

endinterface

// File: rtl/control_unit_fsm_cu_decoder.sv
// Combinational opcode classifier: instruction class, ALU mode and operand selects.
module cu_decoder
  import control_unit_fsm_pkg::*;
(
  input  logic [OPCODE_SIZE-1:0] i_opcode,
  output cu_class_t              o_class,
  output logic                   o_mode,
  output logic                   o_mux_a,
  output logic                   o_mux_b,
  output logic                   o_br_eq
);

  always_comb begin
    o_class = CL_NOP;
    o_mode  = i_opcode[3];
    o_mux_a = i_opcode[0];
    o_mux_b = i_opcode[1];
    o_br_eq = (i_opcode == OP_BEQ);
    // 0x00-0x0F are all ALU ops; bit 3 splits arithmetic from logic
    if (!i_opcode[4]) begin
      o_class = CL_ALU;
    end else begin
      case (i_opcode)
        OP_LD:   o_class = CL_LD;
        OP_ST:   o_class = CL_ST;
        OP_JMP:  o_class = CL_JMP;
        OP_BEQ:  o_class = CL_BR;
        OP_BNE:  o_class = CL_BR;
        OP_HALT: o_class = CL_HALT;
        default: o_class = CL_NOP;
      endcase
    end
  end

endmodule

// File: rtl/control_unit_fsm.sv
// Fetch/decode/execute sequencer driving the control bus; all outputs registered
// from the next state, with a memory-wait timeout that faults into HALT.
module control_unit_fsm
  import control_unit_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ENABLE,
  input  logic [OPCODE_SIZE-1:0] OPCODE,
  input  logic [3:0]             FLAGS,
  control_unit_fsm_if.master     bus,
  output logic                   halted,
  output logic                   fault
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  cu_state_t               r_state, w_state_next;
  logic                    r_phase, w_phase_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt_next, w_cnt_inc;
  logic [OPCODE_SIZE-1:0]  r_opcode, w_op_sel;
  logic [3:0]              r_flags, w_flags_sel;
  cu_ctrl_t                r_ctrl, w_ctrl;
  logic                    r_halted, w_halted_next;
  logic                    r_fault, w_fault_next;
  logic                    w_wait;
  logic                    w_taken;
  cu_state_t               w_boundary;
  cu_class_t               w_class;
  logic                    w_mode, w_mux_a, w_mux_b, w_br_eq;
  logic                    w_flags_unused;

  // EXEC outputs are computed on the DECODE->EXEC edge, before the IR copy lands
  assign w_op_sel    = (r_state == CU_DECODE) ? OPCODE : r_opcode;
  assign w_flags_sel = (r_state == CU_DECODE) ? FLAGS  : r_flags;
  assign w_taken     = w_br_eq ? w_flags_sel[FLAG_Z] : ~w_flags_sel[FLAG_Z];
  assign w_boundary  = ENABLE ? CU_FETCH : CU_IDLE;
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_flags_unused = &{1'b0, w_flags_sel[FLAG_V], w_flags_sel[FLAG_N], w_flags_sel[FLAG_C]};

  cu_decoder u_dec (
    .i_opcode (w_op_sel),
    .o_class  (w_class),
    .o_mode   (w_mode),
    .o_mux_a  (w_mux_a),
    .o_mux_b  (w_mux_b),
    .o_br_eq  (w_br_eq)
  );

  always_comb begin
    w_state_next = r_state;
    w_phase_next = 1'b0;
    w_cnt_next   = '0;
    w_fault_next = r_fault;
    w_wait       = 1'b0;
    case (r_state)
      CU_IDLE:   if (ENABLE) w_state_next = CU_FETCH;
      CU_FETCH: begin
        if (r_phase)            w_state_next = CU_DECODE;
        else if (bus.mem_ready) w_phase_next = 1'b1;
        else                    w_wait       = 1'b1;
      end
      CU_DECODE: w_state_next = CU_EXEC;
      CU_EXEC: begin
        case (w_class)
          CL_LD:   w_state_next = CU_MEM_RD;
          CL_ST:   w_state_next = CU_MEM_WR;
          CL_HALT: w_state_next = CU_HALT;
          default: w_state_next = w_boundary;
        endcase
      end
      CU_MEM_RD: begin
        if (r_phase)            w_state_next = w_boundary;
        else if (bus.mem_ready) w_phase_next = 1'b1;
        else                    w_wait       = 1'b1;
      end
      CU_MEM_WR: begin
        if (bus.mem_ready) w_state_next = w_boundary;
        else               w_wait       = 1'b1;
      end
      CU_HALT:   w_state_next = CU_HALT;
      default:   w_state_next = CU_IDLE;
    endcase
    if (w_wait) begin
      if (w_cnt_inc == CNT_W'(MEM_TIMEOUT)) begin
        w_state_next = CU_HALT;
        w_fault_next = 1'b1;
      end else begin
        w_cnt_next = w_cnt_inc;
      end
    end
    w_halted_next = r_halted | (w_state_next == CU_HALT);
  end

  always_comb begin
    w_ctrl = '0;
    case (w_state_next)
      CU_FETCH: begin
        w_ctrl.load_sel = LS_IR;
        if (w_phase_next) begin
          w_ctrl.load_reg = 1'b1;
          w_ctrl.inc_pc   = 1'b1;
        end else begin
          w_ctrl.rd_en = 1'b1;
        end
      end
      CU_EXEC: begin
        case (w_class)
          CL_ALU: begin
            w_ctrl.mode     = w_mode;
            w_ctrl.mux_a    = w_mux_a;
            w_ctrl.mux_b    = w_mux_b;
            w_ctrl.load_sel = LS_REGA;
            w_ctrl.load_reg = 1'b1;
          end
          CL_JMP: begin
            w_ctrl.load_sel = LS_PC;
            w_ctrl.load_reg = 1'b1;
          end
          CL_BR: begin
            w_ctrl.load_sel = LS_PC;
            w_ctrl.load_reg = w_taken;
          end
          default: w_ctrl = '0;
        endcase
      end
      CU_MEM_RD: begin
        if (w_phase_next) begin
          w_ctrl.load_sel = LS_REGA;
          w_ctrl.load_reg = 1'b1;
        end else begin
          w_ctrl.rd_en = 1'b1;
        end
      end
      CU_MEM_WR: w_ctrl.wr_en = 1'b1;
      default:   w_ctrl = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= CU_IDLE;
      r_phase  <= 1'b0;
      r_cnt    <= '0;
      r_opcode <= '0;
      r_flags  <= '0;
      r_ctrl   <= '0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_phase  <= w_phase_next;
      r_cnt    <= w_cnt_next;
      r_ctrl   <= w_ctrl;
      r_halted <= w_halted_next;
      r_fault  <= w_fault_next;
      if (r_state == CU_DECODE) begin
        r_opcode <= OPCODE;
        r_flags  <= FLAGS;
      end
    end
  end

  assign bus.RD_EN        = r_ctrl.rd_en;
  assign bus.WR_EN        = r_ctrl.wr_en;
  assign bus.INC_PC       = r_ctrl.inc_pc;
  assign bus.LOAD_REG     = r_ctrl.load_reg;
  assign bus.LOAD_SELECT  = r_ctrl.load_sel;
  assign bus.MODE         = r_ctrl.mode;
  assign bus.MUX_SELECT_A = r_ctrl.mux_a;
  assign bus.MUX_SELECT_B = r_ctrl.mux_b;
  assign halted           = r_halted;
  assign fault            = r_fault;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Directed bench for control_unit_fsm: every output checked as one packed vector per step.
module tb_control_unit_fsm;
  import control_unit_fsm_pkg::*;

  logic                   clk;
  logic                   rst_n;
  logic                   ENABLE;
  logic [OPCODE_SIZE-1:0] OPCODE;
  logic [3:0]             FLAGS;
  logic                   halted;
  logic                   fault;
  logic [11:0]            obs;
  int                     checks;
  int                     errors;

  control_unit_fsm_if bus ();

  control_unit_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ENABLE (ENABLE),
    .OPCODE (OPCODE),
    .FLAGS  (FLAGS),
    .bus    (bus.master),
    .halted (halted),
    .fault  (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {bus.RD_EN, bus.WR_EN, bus.INC_PC, bus.LOAD_REG, bus.LOAD_SELECT,
                bus.MODE, bus.MUX_SELECT_A, bus.MUX_SELECT_B, halted, fault};

  function automatic logic [11:0] ctl(input logic rd, input logic wr, input logic inc,
                                      input logic ld, input logic [2:0] ls, input logic m,
                                      input logic a, input logic b, input logic h,
                                      input logic f);
    return {rd, wr, inc, ld, ls, m, a, b, h, f};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
    end
  endtask

  // Starting in FETCH with RD_EN seen: complete the fetch and pass through DECODE.
  task automatic fetch_rest(input string tag);
    bus.mem_ready = 1'b1;
    step();
    chk({tag, "_fetch_done"}, ctl(0,0,1,1,3'b001,0,0,0,0,0));
    bus.mem_ready = 1'b0;
    step();
    chk({tag, "_decode"}, '0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    ENABLE        = 1'b0;
    OPCODE        = '0;
    FLAGS         = '0;
    bus.mem_ready = 1'b0;
    step();
    step();
    chk("reset", '0);
    rst_n = 1'b1;
    step();
    chk("idle_no_enable", '0);

    // ALU add-type 0x03 with a two-cycle fetch wait
    ENABLE = 1'b1;
    OPCODE = 5'h03;
    step();
    chk("alu_fetch_rd1", ctl(1,0,0,0,3'b001,0,0,0,0,0));
    step();
    chk("alu_fetch_rd2", ctl(1,0,0,0,3'b001,0,0,0,0,0));
    fetch_rest("alu");
    step();
    chk("alu_exec", ctl(0,0,0,1,3'b010,0,1,1,0,0));

    // LD
    OPCODE = 5'h10;
    step();
    chk("ld_fetch_rd", ctl(1,0,0,0,3'b001,0,0,0,0,0));
    fetch_rest("ld");
    step();
    chk("ld_exec", '0);
    step();
    chk("ld_memrd1", ctl(1,0,0,0,3'b000,0,0,0,0,0));
    step();
    chk("ld_memrd2", ctl(1,0,0,0,3'b000,0,0,0,0,0));
    bus.mem_ready = 1'b1;
    step();
    chk("ld_load", ctl(0,0,0,1,3'b010,0,0,0,0,0));
    bus.mem_ready = 1'b0;

    // BEQ taken
    OPCODE = 5'h13;
    FLAGS  = 4'b0001;
    step();
    chk("beq_t_fetch_rd", ctl(1,0,0,0,3'b001,0,0,0,0,0));
    fetch_rest("beq_t");
    step();
    chk("beq_t_exec", ctl(0,0,0,1,3'b000,0,0,0,0,0));

    // BEQ not taken: no load, immediate refetch
    FLAGS = 4'b0000;
    step();
    chk("beq_n_fetch_rd", ctl(1,0,0,0,3'b001,0,0,0,0,0));
    fetch_rest("beq_n");
    step();
    chk("beq_n_exec", '0);
    step();
    chk("beq_n_refetch", ctl(1,0,0,0,3'b001,0,0,0,0,0));

    // Logic op 0x0D: MODE=1, A=1, B=0
    OPCODE = 5'h0D;
    FLAGS  = 4'b1111;
    fetch_rest("logic");
    step();
    chk("logic_exec", ctl(0,0,0,1,3'b010,1,1,0,0,0));
    step();
    chk("logic_refetch", ctl(1,0,0,0,3'b001,0,0,0,0,0));

    // BNE taken on Z=0
    OPCODE = 5'h14;
    FLAGS  = 4'b0000;
    fetch_rest("bne");
    step();
    chk("bne_exec", ctl(0,0,0,1,3'b000,0,0,0,0,0));
    step();
    chk("bne_refetch", ctl(1,0,0,0,3'b001,0,0,0,0,0));

    // LD with ENABLE dropped mid-access
    OPCODE = 5'h10;
    fetch_rest("ldoff");
    step();
    chk("ldoff_exec", '0);
    step();
    chk("ldoff_memrd1", ctl(1,0,0,0,3'b000,0,0,0,0,0));
    ENABLE = 1'b0;
    step();
    chk("ldoff_memrd2", ctl(1,0,0,0,3'b000,0,0,0,0,0));
    bus.mem_ready = 1'b1;
    step();
    chk("ldoff_load", ctl(0,0,0,1,3'b010,0,0,0,0,0));
    bus.mem_ready = 1'b0;
    step();
    chk("ldoff_idle1", '0);
    step();
    chk("ldoff_idle2", '0);
    ENABLE = 1'b1;
    step();
    chk("reenable_fetch", ctl(1,0,0,0,3'b001,0,0,0,0,0));

    // ST with mem_ready withheld -> timeout fault
    OPCODE = 5'h11;
    fetch_rest("st");
    step();
    chk("st_exec", '0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("st_wr_wait", ctl(0,1,0,0,3'b000,0,0,0,0,0));
    end
    step();
    chk("st_timeout", ctl(0,0,0,0,3'b000,0,0,0,1,1));
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    chk("halt_sticky1", ctl(0,0,0,0,3'b000,0,0,0,1,1));
    step();
    chk("halt_sticky2", ctl(0,0,0,0,3'b000,0,0,0,1,1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("halt_async_reset", '0);
    #1;
    rst_n = 1'b1;

    // Reset mid-FETCH clears RD_EN without a clock edge
    step();
    chk("pre_reset_fetch", ctl(1,0,0,0,3'b001,0,0,0,0,0));
    rst_n = 1'b0;
    #1;
    chk("fetch_async_reset", '0);
    #2;
    rst_n = 1'b1;

    // HALT opcode
    OPCODE = 5'h1F;
    step();
    chk("halt_fetch_rd", ctl(1,0,0,0,3'b001,0,0,0,0,0));
    fetch_rest("halt");
    step();
    chk("halt_exec", '0);
    step();
    chk("halt_state", ctl(0,0,0,0,3'b000,0,0,0,1,0));
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = 1'b1;
      step();
      bus.mem_ready = 1'b0;
      chk("halt_no_fetch", ctl(0,0,0,0,3'b000,0,0,0,1,0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
